lut_mult_acc_stream: RTL and testbench

Streaming multiply-accumulate stage built around the 8-bit constant-coefficient LUT multiplier (`lut_mult_8bit`). It accepts 8-bit unsigned samples over a valid/ready handshake and registers them. Each sample is multiplied by the fixed constant through one instantiated `lut_mult_8bit`, and the resulting 16-bit products are accumulated over a window of up to `ACC_LEN` samples. The window sum is emitted on a valid/ready output port. It sits directly downstream of the multiplier and consumes its `C` output.

---
 rtl/lut_mult_acc_stream.sv | 192 +++++++++++++++++++
 tb/tb_lut_mult_acc_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_mult_acc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : lut_mult_8bit
//  Purpose  : Multiplies an 8-bit unsigned input by a fixed constant. The
//             constant is folded into a 256-entry ROM at elaboration time.
//  Ports    : X [7:0]  - unsigned operand
//             C [15:0] - X * A_const (A_const <= 257, so the product fits)
//  Revision : 1.0 - initial release
// ============================================================================
module lut_mult_8bit #(
  parameter int A_const = 3
) (
  input  logic [7:0]  X,
  output logic [15:0] C
);

  logic [15:0] w_rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign w_rom[gi] = 16'(gi * A_const);
  end

  assign C = w_rom[X];

endmodule

// ============================================================================
//  Module   : lut_mult_acc_stream
//  Purpose  : Streaming multiply-accumulate. Accepts 8-bit samples over
//             valid/ready, multiplies each by A_CONST through lut_mult_8bit,
//             and sums the products over a window of up to ACC_LEN samples
//             (closed early by in_last). The window result is presented
//             on a valid/ready output port.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready / in_x[7:0] / in_last   - sample stream
//             out_valid / out_ready                       - result handshake
//             out_sum[ACC_W-1:0] - window sum mod 2^ACC_W
//             out_count[7:0]     - samples in the window
//             out_ovf            - sticky accumulator carry-out
//  Revision : 1.0 - initial release
// ============================================================================
module lut_mult_acc_stream #(
  parameter int A_CONST = 3,
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter value seen on the edge that accepts the ACC_LEN-th sample.
  localparam logic [7:0] C_LAST_IDX = 8'(ACC_LEN - 1);

  state_t             state_q,     state_d;
  logic [7:0]         x_q,         x_d;
  logic [15:0]        p_q,         p_d;
  logic               v1_q,        v1_d;
  logic               v2_q,        v2_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic               ovf_q,       ovf_d;
  logic [7:0]         cnt_q,       cnt_d;
  logic [1:0]         drain_q,     drain_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               w_accept;
  logic               w_close;
  logic [15:0]        w_prod;
  logic [ACC_W:0]     w_sum;

  lut_mult_8bit #(
    .A_const (A_CONST)
  ) u_mult (
    .X (x_q),
    .C (w_prod)
  );

  assign w_accept = in_valid && in_ready_q;
  assign w_close  = w_accept && (in_last || (cnt_q == C_LAST_IDX));
  // Extra MSB captures the carry-out of the accumulator add.
  assign w_sum    = {1'b0, acc_q} + {1'b0, ACC_W'(p_q)};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    p_d         = w_prod;
    v1_d        = w_accept;
    v2_d        = v1_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (w_accept) begin
      x_d   = in_x;
      cnt_d = cnt_q + 8'd1;
    end

    if (v2_q) begin
      acc_d = w_sum[ACC_W-1:0];
      ovf_d = ovf_q | w_sum[ACC_W];
    end

    case (state_q)
      ST_RUN: begin
        if (w_close) begin
          state_d    = ST_DRAIN;
          in_ready_d = 1'b0;
          drain_d    = 2'd0;
        end
      end
      // Input is stalled, so the closing sample is the last one in flight;
      // it reaches S3 on the third edge after the closing accept.
      ST_DRAIN: begin
        if (drain_q == 2'd2) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_RUN;
          acc_d       = '0;
          cnt_d       = 8'd0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      x_q         <= 8'd0;
      p_q         <= 16'd0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= 8'd0;
      drain_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      p_q         <= p_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_mult_acc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_mult_acc_stream
//  Purpose  : Self-checking bench for lut_mult_acc_stream. Directed windows
//             followed by randomized traffic, all compared against a
//             window-level arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lut_mult_acc_stream;

  localparam int A_CONST = 255;
  localparam int ACC_LEN = 4;
  localparam int ACC_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  always #5 clk = ~clk;

  lut_mult_acc_stream #(
    .A_CONST (A_CONST),
    .ACC_LEN (ACC_LEN),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: true (unbounded) sum of the open window, its sample
  // count, and whether the window has closed and on which rising edge.
  longint m_sum;
  int     m_cnt;
  bit     m_closed;
  longint m_close_cyc;
  longint cyc;

  logic             obs_valid;
  logic [ACC_W-1:0] obs_sum;
  logic [7:0]       obs_count;
  logic             obs_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sum       = 0;
    m_cnt       = 0;
    m_closed    = 1'b0;
    m_close_cyc = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, drive the inputs for
  // the next rising edge, advance the model, then wait for that edge.
  task automatic step(input bit v, input logic [7:0] x, input bit last, input bit ordy);
    bit     exp_rdy;
    bit     exp_ov;
    longint modw;
    modw = longint'(1) << ACC_W;
    @(negedge clk);
    exp_rdy   = !m_closed;
    exp_ov    = m_closed && (cyc >= m_close_cyc + 3);
    obs_valid = out_valid;
    obs_sum   = out_sum;
    obs_count = out_count;
    obs_ovf   = out_ovf;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_sum", 32'(out_sum), 32'(m_sum % modw));
      check("out_count", 32'(out_count), 32'(m_cnt));
      check("out_ovf", 32'(out_ovf), 32'(m_sum >= modw));
    end
    in_valid  = v;
    in_x      = x;
    in_last   = last;
    out_ready = ordy;
    if (v && exp_rdy) begin
      m_sum += longint'(x) * A_CONST;
      m_cnt++;
      if (last || m_cnt == ACC_LEN) begin
        m_closed    = 1'b1;
        m_close_cyc = cyc + 1;
      end
    end else if (exp_ov && ordy) begin
      model_clear();
    end
    @(posedge clk);
    cyc++;
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must
  // return to reset values without waiting for an edge.
  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_x      = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    cyc++;
  endtask

  // Wait (bounded) for a result with out_ready low, compare it with fixed
  // values, hold it for hold_cycles (offering ignored samples), then accept.
  task automatic expect_result(input string tag, input int sum, input int count,
                               input bit ovf, input int hold_cycles);
    obs_valid = 1'b0;
    for (int i = 0; i < 12 && !obs_valid; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
    check({tag, "_seen"}, 32'(obs_valid), 32'd1);
    check({tag, "_sum"}, 32'(obs_sum), 32'(sum));
    check({tag, "_count"}, 32'(obs_count), 32'(count));
    check({tag, "_ovf"}, 32'(obs_ovf), 32'(ovf));
    for (int i = 0; i < hold_cycles; i++) step(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    cyc       = 0;
    model_clear();
    do_reset();

    // Full window back-to-back with out_ready held high.
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'd3, 1'b0, 1'b1);
    step(1'b1, 8'd4, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // Same window under output backpressure.
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd4, 1'b0, 1'b0);
    expect_result("bp", 2550, 4, 1'b0, 5);

    // Early close with overflow, then a window proving the clear.
    step(1'b1, 8'd255, 1'b0, 1'b0);
    step(1'b1, 8'd255, 1'b1, 1'b0);
    expect_result("ovf", 64514, 2, 1'b1, 0);
    step(1'b1, 8'd7, 1'b1, 1'b0);
    expect_result("clr7", 1785, 1, 1'b0, 0);
    step(1'b1, 8'd1, 1'b1, 1'b0);
    expect_result("clr1", 255, 1, 1'b0, 0);

    // Bubbles and an in_last pulse while in_valid is low.
    step(1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b0, 8'd9, 1'b1, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    expect_result("bubble", 2040, 4, 1'b0, 0);

    // Reset in the middle of a window.
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd6, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'd4, 1'b1, 1'b0);
    expect_result("post_rst", 1020, 1, 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9) < 7), 8'($urandom_range(255)),
           ($urandom_range(7) == 0), $urandom_range(1) == 1);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
